song_reader: RTL and testbench

//  Player-side counterpart of the mcu control interface. Consumes play, reset_player and song[1:0].

---
 rtl/song_reader.sv | 121 ++++++++++++
 tb/tb_song_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
`timescale 1ns/1ps
// song_reader: walks a song ROM note by note and hands each note
// to the note player over a new_note/note_done handshake.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   play         run (1) / pause (0) level from mcu
//   reset_player synchronous clear pulse from mcu
//   song         selected song
//   note_done    note player finished the current note
//   rom_data     {note, duration}, valid one cycle after rom_addr
//   rom_addr     {song, note_idx}, combinational
//   new_note     one-cycle pulse, note/duration valid with it
//   note         current note
//   duration     current duration
//   song_done    one-cycle pulse when the song has finished
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    reset_player,
  input  logic [1:0]              song,
  input  logic                    note_done,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [IDX_W+1:0]        rom_addr,
  output logic                    new_note,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = '1;

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              issue;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];
  assign rom_addr = {song, idx_q};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (play) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        // rom_addr is stable here, so a paused LOAD
        // keeps a valid ROM word until play returns
        if (rom_dur == '0) begin
          state_d = DONE;
        end else if (play) begin
          state_d = WAIT;
          issue   = 1'b1;
        end
      end
      WAIT: begin
        if (note_done) begin
          state_d = (idx_q == LAST) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset_player) begin
      state_d = IDLE;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
      note      <= '0;
      duration  <= '0;
    end else begin
      state_q   <= state_d;
      new_note  <= issue;
      song_done <= (state_d == DONE);
      if (issue) begin
        note     <= rom_note;
        duration <= rom_dur;
      end
      if (reset_player || state_q == DONE) begin
        idx_q <= '0;
      end else if (state_q == WAIT && note_done
                   && idx_q != LAST) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
`timescale 1ns/1ps
// tb_song_reader: directed self-checking bench for song_reader
// with a synchronous ROM model and hand-computed expectations.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0;
  logic        reset_player = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        note_done = 1'b0;
  logic [11:0] rom_data = '0;
  logic [6:0]  rom_addr;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        song_done;

  logic [11:0] rom [128];

  int checks = 0;
  int errors = 0;
  int nn_cnt = 0;
  int sd_cnt = 0;
  int both_cnt = 0;

  song_reader #(
    .NOTE_W(6),
    .DUR_W (6),
    .IDX_W (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .play        (play),
    .reset_player(reset_player),
    .song        (song),
    .note_done   (note_done),
    .rom_data    (rom_data),
    .rom_addr    (rom_addr),
    .new_note    (new_note),
    .note        (note),
    .duration    (duration),
    .song_done   (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) begin
    if (new_note) nn_cnt++;
    if (song_done) sd_cnt++;
    if (new_note && song_done) both_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nn(input int maxc, output int n);
    n = 0;
    while (!new_note && n < maxc) begin
      cyc();
      n++;
    end
    if (!new_note) n = -1;
  endtask

  task automatic wait_sd(input int maxc, output int n);
    n = 0;
    while (!song_done && n < maxc) begin
      cyc();
      n++;
    end
    if (!song_done) n = -1;
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    cyc();
    note_done = 1'b0;
  endtask

  task automatic pulse_rp();
    reset_player = 1'b1;
    cyc();
    reset_player = 1'b0;
  endtask

  initial begin
    int n;
    int nb;
    int sb;
    logic [5:0] t1n [3];

    t1n[0] = 6'd5;
    t1n[1] = 6'd7;
    t1n[2] = 6'd9;
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0] = {6'd5, 6'd4};
    rom[1] = {6'd7, 6'd4};
    rom[2] = {6'd9, 6'd4};
    for (int i = 0; i < 10; i++)
      rom[32+i] = {6'(40 + i), 6'd2};
    rom[64] = {6'd33, 6'd0};
    for (int i = 0; i < 32; i++)
      rom[96+i] = {6'(20 + i), 6'(i % 7 + 1)};

    // reset state
    #12;
    chk("rst_nn", new_note, 0);
    chk("rst_sd", song_done, 0);
    chk("rst_note", note, 0);
    chk("rst_dur", duration, 0);
    chk("rst_addr", rom_addr, 0);
    @(negedge clk) reset = 1'b1;
    cyc();

    // 1: song 0, three notes then end marker
    nb = nn_cnt;
    play = 1'b1;
    wait_nn(20, n);
    chk("t1_lat", n, 3);
    chk("t1_note0", note, 5);
    chk("t1_dur0", duration, 4);
    for (int k = 1; k < 3; k++) begin
      repeat (9) cyc();
      pulse_done();
      wait_nn(20, n);
      chk("t1_gap", n, 2);
      chk("t1_note", note, t1n[k]);
      chk("t1_dur", duration, 4);
    end
    repeat (9) cyc();
    pulse_done();
    wait_sd(20, n);
    chk("t1_sd_lat", n, 2);
    chk("t1_sd_nn", new_note, 0);
    play = 1'b0;
    cyc();
    chk("t1_sd_off", song_done, 0);
    chk("t1_addr", rom_addr, 7'h00);
    repeat (3) cyc();
    chk("t1_cnt", nn_cnt - nb, 3);
    chk("t1_idle", new_note, 0);

    // 2: pause while waiting
    nb = nn_cnt;
    play = 1'b1;
    wait_nn(20, n);
    chk("t2_lat", n, 3);
    chk("t2_note0", note, 5);
    play = 1'b0;
    repeat (5) cyc();
    pulse_done();
    repeat (15) cyc();
    chk("t2_hold", nn_cnt - nb, 1);
    chk("t2_hold_nn", new_note, 0);
    chk("t2_hold_addr", rom_addr, 7'h01);
    play = 1'b1;
    wait_nn(20, n);
    chk("t2_resume", n, 1);
    chk("t2_note1", note, 7);
    repeat (4) cyc();
    pulse_done();
    wait_nn(20, n);
    chk("t2_gap", n, 2);
    chk("t2_note2", note, 9);
    repeat (4) cyc();
    pulse_done();
    wait_sd(20, n);
    chk("t2_sd_lat", n, 2);
    play = 1'b0;
    repeat (3) cyc();
    chk("t2_cnt", nn_cnt - nb, 3);

    // 3: full-length song 3
    song = 2'd3;
    pulse_rp();
    nb = nn_cnt;
    sb = sd_cnt;
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_nn(20, n);
      chk("t3_lat", n, (i == 0) ? 3 : 2);
      chk("t3_note", note, 20 + i);
      chk("t3_dur", duration, i % 7 + 1);
      chk("t3_addr", rom_addr, 96 + i);
      repeat (2) cyc();
      pulse_done();
    end
    wait_sd(20, n);
    chk("t3_sd_lat", n, 0);
    play = 1'b0;
    repeat (4) cyc();
    chk("t3_cnt", nn_cnt - nb, 32);
    chk("t3_sd_cnt", sd_cnt - sb, 1);
    chk("t3_addr_end", rom_addr, 7'h60);

    // 4: reset_player coincident with note_done
    song = 2'd1;
    pulse_rp();
    sb = sd_cnt;
    play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_nn(20, n);
      chk("t4_note", note, 40 + i);
      if (i < 4) begin
        repeat (2) cyc();
        pulse_done();
      end
    end
    chk("t4_addr4", rom_addr, 7'h24);
    note_done = 1'b1;
    reset_player = 1'b1;
    play = 1'b0;
    cyc();
    note_done = 1'b0;
    reset_player = 1'b0;
    chk("t4_addr", rom_addr, 7'h20);
    repeat (5) cyc();
    chk("t4_no_sd", sd_cnt - sb, 0);
    chk("t4_nn", new_note, 0);
    play = 1'b1;
    wait_nn(20, n);
    chk("t4_lat", n, 3);
    chk("t4_note0", note, 40);
    chk("t4_dur0", duration, 2);

    // 5: async reset in WAIT, off the clock edge
    #2 reset = 1'b0;
    #1;
    chk("t5_nn", new_note, 0);
    chk("t5_note", note, 0);
    chk("t5_dur", duration, 0);
    chk("t5_sd", song_done, 0);
    chk("t5_addr", rom_addr, 7'h20);
    @(negedge clk) reset = 1'b1;
    wait_nn(20, n);
    chk("t5_lat", n, 3);
    chk("t5_note0", note, 40);
    chk("t5_addr0", rom_addr, 7'h20);
    play = 1'b0;

    // 6: song 2 starts with end marker
    song = 2'd2;
    pulse_rp();
    cyc();
    nb = nn_cnt;
    sb = sd_cnt;
    play = 1'b1;
    wait_sd(20, n);
    chk("t6_sd_lat", n, 3);
    play = 1'b0;
    repeat (3) cyc();
    chk("t6_no_nn", nn_cnt - nb, 0);
    chk("t6_sd_cnt", sd_cnt - sb, 1);

    chk("overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
